decode_stage: RTL and testbench

Second stage of the 5-stage MIPS pipeline, directly downstream of the fetch stage. It decodes the IF/ID instruction and reads operands through the register-file ports, with EX/MEM forwarding. It resolves branches and jumps with one delay slot, detects load-use hazards, drives `PC_next` and `IRWrite` back to fetch, and registers the ID/EX pipeline outputs.

---
 rtl/decode_stage_if.sv | 45 ++++
 rtl/decode_stage.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Fetch, register-file, EX/MEM bypass and ID/EX signals of the decode stage.
interface decode_stage_if;
  logic [31:0] PC_IF_ID;
  logic [31:0] PC_add_4_IF_ID;
  logic [31:0] Inst_IF_ID;
  logic [31:0] PC_next;
  logic        IRWrite;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        ex_regwrite;
  logic        ex_is_load;
  logic [4:0]  ex_wdest;
  logic [31:0] ex_result;
  logic        mem_regwrite;
  logic [4:0]  mem_wdest;
  logic [31:0] mem_result;
  logic [3:0]  ALUop_ID_EX;
  logic [31:0] ALUA_ID_EX;
  logic [31:0] ALUB_ID_EX;
  logic [31:0] StoreData_ID_EX;
  logic        MemEn_ID_EX;
  logic        MemWEn_ID_EX;
  logic        RegWrite_ID_EX;
  logic [4:0]  Wdest_ID_EX;

  modport master (
    output PC_IF_ID, PC_add_4_IF_ID, Inst_IF_ID, rf_rdata1, rf_rdata2,
           ex_regwrite, ex_is_load, ex_wdest, ex_result,
           mem_regwrite, mem_wdest, mem_result,
    input  PC_next, IRWrite, rf_raddr1, rf_raddr2,
           ALUop_ID_EX, ALUA_ID_EX, ALUB_ID_EX, StoreData_ID_EX,
           MemEn_ID_EX, MemWEn_ID_EX, RegWrite_ID_EX, Wdest_ID_EX
  );

  modport slave (
    input  PC_IF_ID, PC_add_4_IF_ID, Inst_IF_ID, rf_rdata1, rf_rdata2,
           ex_regwrite, ex_is_load, ex_wdest, ex_result,
           mem_regwrite, mem_wdest, mem_result,
    output PC_next, IRWrite, rf_raddr1, rf_raddr2,
           ALUop_ID_EX, ALUA_ID_EX, ALUB_ID_EX, StoreData_ID_EX,
           MemEn_ID_EX, MemWEn_ID_EX, RegWrite_ID_EX, Wdest_ID_EX
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS ID stage: decode, EX/MEM forwarding, delay-slot branch resolution, load-use stall.
// ID/EX is registered (1 cycle); PC_next and IRWrite are combinational.
module decode_stage #(
  parameter logic [31:0] reset_addr = 32'hbfc00000
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  logic [31:0] inst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [25:0] index;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign inst     = bus.Inst_IF_ID;
  assign opcode   = inst[31:26];
  assign rs       = inst[25:21];
  assign rt       = inst[20:16];
  assign rd       = inst[15:11];
  assign shamt    = inst[10:6];
  assign funct    = inst[5:0];
  assign imm      = inst[15:0];
  assign index    = inst[25:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};

  assign bus.rf_raddr1 = rs;
  assign bus.rf_raddr2 = rt;

  function automatic logic [31:0] bypass(
    input logic [4:0]  r,
    input logic [31:0] rf_val,
    input logic        ex_en,
    input logic [4:0]  ex_dst,
    input logic [31:0] ex_val,
    input logic        mem_en,
    input logic [4:0]  mem_dst,
    input logic [31:0] mem_val
  );
    if (r == 5'd0)                         return 32'd0;
    else if (ex_en && (ex_dst == r))       return ex_val;
    else if (mem_en && (mem_dst == r))     return mem_val;
    else                                   return rf_val;
  endfunction

  logic [31:0] rs_val;
  logic [31:0] rt_val;

  assign rs_val = bypass(rs, bus.rf_rdata1, bus.ex_regwrite, bus.ex_wdest, bus.ex_result,
                         bus.mem_regwrite, bus.mem_wdest, bus.mem_result);
  assign rt_val = bypass(rt, bus.rf_rdata2, bus.ex_regwrite, bus.ex_wdest, bus.ex_result,
                         bus.mem_regwrite, bus.mem_wdest, bus.mem_result);

  logic [3:0]  d_op;
  logic [31:0] d_a;
  logic [31:0] d_b;
  logic [31:0] d_sd;
  logic        d_men;
  logic        d_mwen;
  logic        d_rw;
  logic [4:0]  d_wd;
  logic        use_rs;
  logic        use_rt;
  logic        r_alu;
  logic        r_shift;
  logic        i_alu;
  logic        is_beq;
  logic        is_bne;
  logic        is_j;
  logic        is_jal;
  logic        is_jr;

  always_comb begin
    d_op    = ALU_ADD;
    d_a     = 32'd0;
    d_b     = 32'd0;
    d_sd    = 32'd0;
    d_men   = 1'b0;
    d_mwen  = 1'b0;
    d_rw    = 1'b0;
    d_wd    = 5'd0;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    r_alu   = 1'b0;
    r_shift = 1'b0;
    i_alu   = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    is_jal  = 1'b0;
    is_jr   = 1'b0;

    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          F_ADDU: begin r_alu = 1'b1; d_op = ALU_ADD;  end
          F_SUBU: begin r_alu = 1'b1; d_op = ALU_SUB;  end
          F_AND:  begin r_alu = 1'b1; d_op = ALU_AND;  end
          F_OR:   begin r_alu = 1'b1; d_op = ALU_OR;   end
          F_XOR:  begin r_alu = 1'b1; d_op = ALU_XOR;  end
          F_NOR:  begin r_alu = 1'b1; d_op = ALU_NOR;  end
          F_SLT:  begin r_alu = 1'b1; d_op = ALU_SLT;  end
          F_SLTU: begin r_alu = 1'b1; d_op = ALU_SLTU; end
          F_SLL:  begin r_shift = 1'b1; d_op = ALU_SLL; end
          F_SRL:  begin r_shift = 1'b1; d_op = ALU_SRL; end
          F_SRA:  begin r_shift = 1'b1; d_op = ALU_SRA; end
          F_JR:   begin is_jr = 1'b1; use_rs = 1'b1; end
          default: ;
        endcase
        // The all-zero word is the IF/ID reset value; it must stay a pure bubble.
        if (inst == 32'd0) begin
          r_shift = 1'b0;
          d_op    = ALU_ADD;
        end
        if (r_alu) begin
          use_rs = 1'b1;
          use_rt = 1'b1;
          d_a    = rs_val;
          d_b    = rt_val;
          d_rw   = 1'b1;
          d_wd   = rd;
        end
        if (r_shift) begin
          use_rt = 1'b1;
          d_a    = {27'd0, shamt};
          d_b    = rt_val;
          d_rw   = 1'b1;
          d_wd   = rd;
        end
      end
      OP_ADDIU: begin i_alu = 1'b1; d_op = ALU_ADD;  d_b = imm_sext; end
      OP_SLTI:  begin i_alu = 1'b1; d_op = ALU_SLT;  d_b = imm_sext; end
      OP_SLTIU: begin i_alu = 1'b1; d_op = ALU_SLTU; d_b = imm_sext; end
      OP_ANDI:  begin i_alu = 1'b1; d_op = ALU_AND;  d_b = imm_zext; end
      OP_ORI:   begin i_alu = 1'b1; d_op = ALU_OR;   d_b = imm_zext; end
      OP_XORI:  begin i_alu = 1'b1; d_op = ALU_XOR;  d_b = imm_zext; end
      OP_LUI: begin
        d_b  = {imm, 16'h0000};
        d_rw = 1'b1;
        d_wd = rt;
      end
      OP_LW: begin
        use_rs = 1'b1;
        d_a    = rs_val;
        d_b    = imm_sext;
        d_men  = 1'b1;
        d_rw   = 1'b1;
        d_wd   = rt;
      end
      OP_SW: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        d_a    = rs_val;
        d_b    = imm_sext;
        d_sd   = rt_val;
        d_men  = 1'b1;
        d_mwen = 1'b1;
      end
      OP_BEQ: begin is_beq = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      OP_BNE: begin is_bne = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      OP_J:   is_j = 1'b1;
      OP_JAL: begin
        is_jal = 1'b1;
        d_a    = bus.PC_IF_ID + 32'd8;
        d_rw   = 1'b1;
        d_wd   = 5'd31;
      end
      default: ;
    endcase

    if (i_alu) begin
      use_rs = 1'b1;
      d_a    = rs_val;
      d_rw   = 1'b1;
      d_wd   = rt;
    end
  end

  logic        hazard;
  logic        taken;
  logic [31:0] target;
  logic [31:0] br_off;

  assign hazard = bus.ex_is_load && (bus.ex_wdest != 5'd0) &&
                  ((use_rs && (bus.ex_wdest == rs)) || (use_rt && (bus.ex_wdest == rt)));

  assign br_off = {{14{imm[15]}}, imm, 2'b00};
  assign taken  = (is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val)) ||
                  is_j || is_jal || is_jr;

  always_comb begin
    target = bus.PC_add_4_IF_ID + br_off;
    if (is_jr)
      target = rs_val;
    else if (is_j || is_jal)
      target = {bus.PC_add_4_IF_ID[31:28], index, 2'b00};
  end

  logic        boot_r;
  logic        br_pend_r;
  logic [31:0] br_target_r;

  assign bus.IRWrite = rst || !hazard;
  assign bus.PC_next = (rst || boot_r) ? reset_addr :
                       br_pend_r       ? br_target_r : bus.PC_add_4_IF_ID;

  logic [3:0]  alu_op_r;
  logic [31:0] alu_a_r;
  logic [31:0] alu_b_r;
  logic [31:0] store_r;
  logic        men_r;
  logic        mwen_r;
  logic        rw_r;
  logic [4:0]  wd_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      boot_r      <= 1'b1;
      br_pend_r   <= 1'b0;
      br_target_r <= 32'd0;
      alu_op_r    <= ALU_ADD;
      alu_a_r     <= 32'd0;
      alu_b_r     <= 32'd0;
      store_r     <= 32'd0;
      men_r       <= 1'b0;
      mwen_r      <= 1'b0;
      rw_r        <= 1'b0;
      wd_r        <= 5'd0;
    end else if (hazard) begin
      // Stall: fetch-side state holds, ID/EX takes a bubble.
      alu_op_r <= ALU_ADD;
      alu_a_r  <= 32'd0;
      alu_b_r  <= 32'd0;
      store_r  <= 32'd0;
      men_r    <= 1'b0;
      mwen_r   <= 1'b0;
      rw_r     <= 1'b0;
      wd_r     <= 5'd0;
    end else begin
      boot_r    <= 1'b0;
      br_pend_r <= taken;
      if (taken)
        br_target_r <= target;
      alu_op_r <= d_op;
      alu_a_r  <= d_a;
      alu_b_r  <= d_b;
      store_r  <= d_sd;
      men_r    <= d_men;
      mwen_r   <= d_mwen;
      rw_r     <= d_rw;
      wd_r     <= d_wd;
    end
  end

  assign bus.ALUop_ID_EX     = alu_op_r;
  assign bus.ALUA_ID_EX      = alu_a_r;
  assign bus.ALUB_ID_EX      = alu_b_r;
  assign bus.StoreData_ID_EX = store_r;
  assign bus.MemEn_ID_EX     = men_r;
  assign bus.MemWEn_ID_EX    = mwen_r;
  assign bus.RegWrite_ID_EX  = rw_r;
  assign bus.Wdest_ID_EX     = wd_r;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: mnemonic-level reference model, directed plan cases, random traffic.
module tb_decode_stage;
  localparam logic [31:0] RA = 32'hbfc00000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_stage_if bus();
  decode_stage #(.reset_addr(RA)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic        men;
    logic        mwen;
    logic        rw;
    logic [4:0]  wd;
  } idex_t;

  typedef struct packed {
    logic [31:0] pcn;
    logic        irw;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
  } comb_t;

  idex_t q_idex[$];
  comb_t q_comb[$];
  int    n_pass  = 0;
  int    n_total = 0;

  bit          m_boot = 1'b1;
  bit          m_pend = 1'b0;
  logic [31:0] m_tgt  = 32'd0;

  string names [0:26] = '{"ADDU","SUBU","AND","OR","XOR","NOR","SLT","SLTU","SLL","SRL","SRA",
                          "ADDIU","SLTI","SLTIU","ANDI","ORI","XORI","LUI","LW","SW",
                          "BEQ","BNE","J","JAL","JR","BAD","ZERO"};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] enc(input string m, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [4:0] sh,
                                      input logic [15:0] imm, input logic [25:0] idx);
    case (m)
      "ADDU":  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      "SUBU":  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
      "AND":   return {6'h00, rs, rt, rd, 5'd0, 6'h24};
      "OR":    return {6'h00, rs, rt, rd, 5'd0, 6'h25};
      "XOR":   return {6'h00, rs, rt, rd, 5'd0, 6'h26};
      "NOR":   return {6'h00, rs, rt, rd, 5'd0, 6'h27};
      "SLT":   return {6'h00, rs, rt, rd, 5'd0, 6'h2a};
      "SLTU":  return {6'h00, rs, rt, rd, 5'd0, 6'h2b};
      "SLL":   return {6'h00, 5'd0, rt, rd, sh, 6'h00};
      "SRL":   return {6'h00, 5'd0, rt, rd, sh, 6'h02};
      "SRA":   return {6'h00, 5'd0, rt, rd, sh, 6'h03};
      "JR":    return {6'h00, rs, 15'd0, 6'h08};
      "ADDIU": return {6'h09, rs, rt, imm};
      "SLTI":  return {6'h0a, rs, rt, imm};
      "SLTIU": return {6'h0b, rs, rt, imm};
      "ANDI":  return {6'h0c, rs, rt, imm};
      "ORI":   return {6'h0d, rs, rt, imm};
      "XORI":  return {6'h0e, rs, rt, imm};
      "LUI":   return {6'h0f, 5'd0, rt, imm};
      "LW":    return {6'h23, rs, rt, imm};
      "SW":    return {6'h2b, rs, rt, imm};
      "BEQ":   return {6'h04, rs, rt, imm};
      "BNE":   return {6'h05, rs, rt, imm};
      "J":     return {6'h02, idx};
      "JAL":   return {6'h03, idx};
      "BAD":   return {6'h3f, idx};
      default: return 32'd0;
    endcase
  endfunction

  function automatic string mnem(input logic [31:0] i);
    logic [5:0] op;
    logic [5:0] fn;
    op = i[31:26];
    fn = i[5:0];
    if (i == 32'd0) return "BAD";
    if (op == 6'h00) begin
      case (fn)
        6'h00: return "SLL";   6'h02: return "SRL";   6'h03: return "SRA";
        6'h08: return "JR";    6'h21: return "ADDU";  6'h23: return "SUBU";
        6'h24: return "AND";   6'h25: return "OR";    6'h26: return "XOR";
        6'h27: return "NOR";   6'h2a: return "SLT";   6'h2b: return "SLTU";
        default: return "BAD";
      endcase
    end
    case (op)
      6'h02: return "J";     6'h03: return "JAL";   6'h04: return "BEQ";
      6'h05: return "BNE";   6'h09: return "ADDIU"; 6'h0a: return "SLTI";
      6'h0b: return "SLTIU"; 6'h0c: return "ANDI";  6'h0d: return "ORI";
      6'h0e: return "XORI";  6'h0f: return "LUI";   6'h23: return "LW";
      6'h2b: return "SW";
      default: return "BAD";
    endcase
  endfunction

  function automatic logic [3:0] aluc(input string m);
    case (m)
      "AND", "ANDI":   return 4'b0000;
      "OR", "ORI":     return 4'b0001;
      "SLTU", "SLTIU": return 4'b0011;
      "SUBU":          return 4'b0110;
      "SLT", "SLTI":   return 4'b0111;
      "XOR", "XORI":   return 4'b1000;
      "SLL":           return 4'b1001;
      "SRL":           return 4'b1010;
      "SRA":           return 4'b1011;
      "NOR":           return 4'b1100;
      default:         return 4'b0010;
    endcase
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] rf,
                                        input logic exrw, input logic [4:0] exwd, input logic [31:0] exres,
                                        input logic memrw, input logic [4:0] memwd, input logic [31:0] memres);
    if (r == 0) return 32'd0;
    if (exrw && exwd == r) return exres;
    if (memrw && memwd == r) return memres;
    return rf;
  endfunction

  function automatic idex_t bubble();
    idex_t e;
    e = '0;
    e.op = 4'b0010;
    return e;
  endfunction

  function automatic idex_t m_decode(input string m, input logic [31:0] i, input logic [31:0] pc,
                                     input logic [31:0] a, input logic [31:0] b);
    idex_t e;
    logic [31:0] sx;
    logic [31:0] zx;
    e  = bubble();
    sx = {{16{i[15]}}, i[15:0]};
    zx = {16'h0, i[15:0]};
    case (m)
      "ADDU", "SUBU", "AND", "OR", "XOR", "NOR", "SLT", "SLTU": begin
        e.op = aluc(m); e.a = a; e.b = b; e.rw = 1; e.wd = i[15:11];
      end
      "SLL", "SRL", "SRA": begin
        e.op = aluc(m); e.a = {27'd0, i[10:6]}; e.b = b; e.rw = 1; e.wd = i[15:11];
      end
      "ADDIU", "SLTI", "SLTIU": begin
        e.op = aluc(m); e.a = a; e.b = sx; e.rw = 1; e.wd = i[20:16];
      end
      "ANDI", "ORI", "XORI": begin
        e.op = aluc(m); e.a = a; e.b = zx; e.rw = 1; e.wd = i[20:16];
      end
      "LUI": begin e.b = {i[15:0], 16'h0}; e.rw = 1; e.wd = i[20:16]; end
      "LW":  begin e.a = a; e.b = sx; e.men = 1; e.rw = 1; e.wd = i[20:16]; end
      "SW":  begin e.a = a; e.b = sx; e.sd = b; e.men = 1; e.mwen = 1; end
      "JAL": begin e.a = pc + 32'd8; e.rw = 1; e.wd = 5'd31; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic step(input logic r, input logic [31:0] pc, input logic [31:0] inst,
                      input logic [31:0] d1, input logic [31:0] d2,
                      input logic exrw, input logic exld, input logic [4:0] exwd, input logic [31:0] exres,
                      input logic memrw, input logic [4:0] memwd, input logic [31:0] memres);
    string m;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc4;
    logic urs;
    logic urt;
    logic haz;
    comb_t c;
    idex_t e;
    @(negedge clk);
    rst = r;
    bus.PC_IF_ID = pc;
    bus.PC_add_4_IF_ID = pc + 32'd4;
    bus.Inst_IF_ID = inst;
    bus.rf_rdata1 = d1;
    bus.rf_rdata2 = d2;
    bus.ex_regwrite = exrw;
    bus.ex_is_load = exld;
    bus.ex_wdest = exwd;
    bus.ex_result = exres;
    bus.mem_regwrite = memrw;
    bus.mem_wdest = memwd;
    bus.mem_result = memres;

    m   = mnem(inst);
    rs  = inst[25:21];
    rt  = inst[20:16];
    pc4 = pc + 32'd4;
    a   = m_fwd(rs, d1, exrw, exwd, exres, memrw, memwd, memres);
    b   = m_fwd(rt, d2, exrw, exwd, exres, memrw, memwd, memres);
    case (m)
      "SLL", "SRL", "SRA", "LUI", "J", "JAL", "BAD": urs = 0;
      default: urs = 1;
    endcase
    case (m)
      "ADDU", "SUBU", "AND", "OR", "XOR", "NOR", "SLT", "SLTU",
      "SLL", "SRL", "SRA", "SW", "BEQ", "BNE": urt = 1;
      default: urt = 0;
    endcase
    haz = exld && (exwd != 0) && ((urs && exwd == rs) || (urt && exwd == rt));

    c.ra1 = rs;
    c.ra2 = rt;
    e = bubble();
    if (r) begin
      c.pcn = RA; c.irw = 1;
      m_boot = 1; m_pend = 0; m_tgt = 32'd0;
    end else begin
      c.pcn = m_boot ? RA : (m_pend ? m_tgt : pc4);
      c.irw = !haz;
      if (!haz) begin
        e = m_decode(m, inst, pc, a, b);
        m_boot = 0;
        m_pend = 1;
        case (m)
          "BEQ":      if (a == b) m_tgt = pc4 + {{14{inst[15]}}, inst[15:0], 2'b00}; else m_pend = 0;
          "BNE":      if (a != b) m_tgt = pc4 + {{14{inst[15]}}, inst[15:0], 2'b00}; else m_pend = 0;
          "J", "JAL": m_tgt = {pc4[31:28], inst[25:0], 2'b00};
          "JR":       m_tgt = a;
          default:    m_pend = 0;
        endcase
      end
    end
    q_comb.push_back(c);
    q_idex.push_back(e);
  endtask

  task automatic quiet(input logic r, input logic [31:0] pc, input logic [31:0] inst);
    step(r, pc, inst, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  function automatic logic [31:0] rv();
    if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 3));
    return $urandom;
  endfunction

  always @(negedge clk) begin
    comb_t ex;
    #2;
    if (q_comb.size() > 0) begin
      ex = q_comb.pop_front();
      chk("PC_next", bus.PC_next, ex.pcn);
      chk("IRWrite", {31'd0, bus.IRWrite}, {31'd0, ex.irw});
      chk("rf_raddr", {22'd0, bus.rf_raddr1, bus.rf_raddr2}, {22'd0, ex.ra1, ex.ra2});
    end
  end

  always @(posedge clk) begin
    idex_t ex;
    #1;
    if (q_idex.size() > 0) begin
      ex = q_idex.pop_front();
      chk("ALUop", {28'd0, bus.ALUop_ID_EX}, {28'd0, ex.op});
      chk("ALUA", bus.ALUA_ID_EX, ex.a);
      chk("ALUB", bus.ALUB_ID_EX, ex.b);
      chk("StoreData", bus.StoreData_ID_EX, ex.sd);
      chk("ctrl men/mwen/rw", {29'd0, bus.MemEn_ID_EX, bus.MemWEn_ID_EX, bus.RegWrite_ID_EX},
          {29'd0, ex.men, ex.mwen, ex.rw});
      chk("Wdest", {27'd0, bus.Wdest_ID_EX}, {27'd0, ex.wd});
    end
  end

  initial begin
    logic [31:0] i_addu;
    string m;
    bus.PC_IF_ID = 0; bus.PC_add_4_IF_ID = 0; bus.Inst_IF_ID = 0;
    bus.rf_rdata1 = 0; bus.rf_rdata2 = 0;
    bus.ex_regwrite = 0; bus.ex_is_load = 0; bus.ex_wdest = 0; bus.ex_result = 0;
    bus.mem_regwrite = 0; bus.mem_wdest = 0; bus.mem_result = 0;

    quiet(1, 0, 0);
    quiet(1, 0, 0);
    quiet(0, 0, 0);
    #2 chk("boot PC", bus.PC_next, 32'hbfc00000);
    quiet(0, RA, 0);
    #2 chk("second PC", bus.PC_next, 32'hbfc00004);

    step(0, RA + 4, enc("ADDU", 1, 2, 3, 0, 0, 0), 9, 11, 1, 0, 1, 5, 1, 1, 7);
    @(posedge clk); #1 chk("fwd EX priority", bus.ALUA_ID_EX, 32'd5);
    step(0, RA + 8, enc("ADDU", 0, 2, 3, 0, 0, 0), 9, 11, 1, 0, 0, 123, 1, 0, 77);
    @(posedge clk); #1 chk("fwd zero reg", bus.ALUA_ID_EX, 32'd0);

    i_addu = enc("ADDU", 4, 4, 5, 0, 0, 0);
    step(0, RA + 12, i_addu, 1, 1, 1, 1, 4, 32'h100, 0, 0, 0);
    #2 chk("load-use stall", {31'd0, bus.IRWrite}, 32'd0);
    step(0, RA + 12, i_addu, 1, 1, 0, 0, 0, 0, 1, 4, 32'h1234);
    #2 chk("after stall", {31'd0, bus.IRWrite}, 32'd1);
    @(posedge clk); #1 chk("load-use MEM data", bus.ALUB_ID_EX, 32'h1234);

    step(0, 32'hbfc00010, enc("BEQ", 1, 1, 0, 0, 16'd3, 0), 42, 42, 0, 0, 0, 0, 0, 0, 0);
    #2 chk("BEQ delay slot fetch", bus.PC_next, 32'hbfc00014);
    quiet(0, 32'hbfc00014, 0);
    #2 chk("BEQ target", bus.PC_next, 32'hbfc00020);
    quiet(0, 32'hbfc00020, 0);

    step(0, 32'hbfc00100, enc("JAL", 0, 0, 0, 0, 0, 26'h3f00080), 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 chk("JAL link", bus.ALUA_ID_EX, 32'hbfc00108);
    chk("JAL wdest", {27'd0, bus.Wdest_ID_EX}, 32'd31);
    quiet(0, 32'hbfc00104, 0);
    #2 chk("JAL target", bus.PC_next, 32'hbfc00200);
    quiet(0, 32'hbfc00200, 0);

    step(0, 32'hbfc00300, enc("J", 0, 0, 0, 0, 0, 26'h0001234), 0, 0, 0, 0, 0, 0, 0, 0, 0);
    quiet(1, 32'hbfc00304, 0);
    quiet(0, 0, 0);
    #2 chk("reset drops branch", bus.PC_next, RA);

    for (int k = 0; k < 600; k++) begin
      logic [31:0] pc;
      logic [31:0] inst;
      logic exrw;
      m  = names[$urandom_range(0, 26)];
      pc = $urandom & 32'hffff_fffc;
      inst = enc(m, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                 5'($urandom_range(0, 31)), 16'($urandom), 26'($urandom));
      if ($urandom_range(0, 9) == 0 && m == "BAD") inst = {6'h00, 20'($urandom), 6'h3f};
      exrw = 1'($urandom_range(0, 1));
      step($urandom_range(0, 59) == 0, pc, inst, rv(), rv(),
           exrw, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 5)), rv(),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 5)), rv());
    end

    @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
